// File: rtl/riscv_dmws.sv
// riscv_dmws: wait-stated RV64I data memory that stalls the pipeline until each load/store completes.
// Ports: clk, async active-low rst; req/wen/sel/addr/wdata from the memory stage;
// rdata (lane-aligned, zero-filled), stall to the hazard unit, done pulse, misalign qualifying done.
module riscv_dmws #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 1024,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 1
) (
  input  logic            i_riscv_dmws_clk,
  input  logic            i_riscv_dmws_rst,
  input  logic            i_riscv_dmws_req,
  input  logic            i_riscv_dmws_wen,
  input  logic [1:0]      i_riscv_dmws_sel,
  input  logic [XLEN-1:0] i_riscv_dmws_addr,
  input  logic [XLEN-1:0] i_riscv_dmws_wdata,
  output logic [XLEN-1:0] o_riscv_dmws_rdata,
  output logic            o_riscv_dmws_stall,
  output logic            o_riscv_dmws_done,
  output logic            o_riscv_dmws_misalign
);
  localparam int AW = $clog2(DEPTH);
  localparam int OB = $clog2(XLEN / 8);
  localparam int MW = WAIT_RD > WAIT_WR ? WAIT_RD : WAIT_WR;
  localparam int CW = MW > 0 ? $clog2(MW + 1) : 1;
  localparam logic [CW-1:0] CNT_RD = CW'(WAIT_RD > 0 ? WAIT_RD - 1 : 0);
  localparam logic [CW-1:0] CNT_WR = CW'(WAIT_WR > 0 ? WAIT_WR - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+OB-1:0] addr_q, addr;
  logic [1:0] sel_q, sel;
  logic wen_q, wen, mis_q, mis;
  logic [XLEN-1:0] wdata_q, rdata_q, wdata, word, szm, ld;
  logic [XLEN-1:0] mem [DEPTH];
  logic [OB-1:0] off;
  logic [OB+2:0] sh;
  logic idle, req_ok, wait_st, go, bypass, fin, wr;
  logic unused_addr;
  assign unused_addr = ^i_riscv_dmws_addr[XLEN-1:AW+OB];
  // In IDLE the live inputs drive the access; afterwards only the captured copy is used.
  assign idle    = st_q == IDLE;
  assign req_ok  = i_riscv_dmws_rst & i_riscv_dmws_req;
  assign wen     = idle ? i_riscv_dmws_wen : wen_q;
  assign sel     = idle ? i_riscv_dmws_sel : sel_q;
  assign addr    = idle ? i_riscv_dmws_addr[AW+OB-1:0] : addr_q;
  assign wdata   = idle ? i_riscv_dmws_wdata : wdata_q;
  assign wait_st = (wen ? WAIT_WR : WAIT_RD) != 0;
  assign go      = idle & req_ok & wait_st;
  assign bypass  = idle & req_ok & !wait_st;
  assign fin     = st_q == BUSY & i_riscv_dmws_req & cnt_q == '0;
  assign off     = addr[OB-1:0];
  assign sh      = {off, 3'b000};
  assign mis     = sel == 2'd1 ? off[0] : sel == 2'd2 ? |off[1:0] : sel == 2'd3 ? |off : 1'b0;
  assign word    = mem[addr[AW+OB-1:OB]];
  assign szm     = sel == 2'd3 ? '1 : (XLEN'(1) << (7'd8 << sel)) - XLEN'(1);
  assign ld      = mis ? '0 : (word >> sh) & szm;
  assign wr      = (bypass | fin) & wen & !mis;
  always_ff @(posedge i_riscv_dmws_clk)
    if (wr) mem[addr[AW+OB-1:OB]] <= (word & ~(szm << sh)) | ((wdata & szm) << sh);
  // An aborted access (req dropped in BUSY) returns to IDLE without touching memory or rdata.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (go) begin
      st_d  = BUSY;
      cnt_d = i_riscv_dmws_wen ? CNT_WR : CNT_RD;
    end else if (st_q == BUSY) begin
      st_d  = !i_riscv_dmws_req ? IDLE : cnt_q == '0 ? DONE : BUSY;
      cnt_d = cnt_q - 1'b1;
    end else if (st_q == DONE) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge i_riscv_dmws_clk or negedge i_riscv_dmws_rst) begin
    if (!i_riscv_dmws_rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (go) begin
        addr_q  <= i_riscv_dmws_addr[AW+OB-1:0];
        sel_q   <= i_riscv_dmws_sel;
        wen_q   <= i_riscv_dmws_wen;
        wdata_q <= i_riscv_dmws_wdata;
      end
      if (fin) mis_q <= mis;
      if ((bypass | fin) & !wen) rdata_q <= ld;
    end
  end
  assign o_riscv_dmws_stall    = go | st_q == BUSY;
  assign o_riscv_dmws_done     = bypass | st_q == DONE;
  assign o_riscv_dmws_misalign = bypass ? mis : st_q == DONE & mis_q;
  assign o_riscv_dmws_rdata    = bypass & !wen ? ld : rdata_q;
endmodule

// File: tb/tb_riscv_dmws.sv
// tb_riscv_dmws: vector table, corner sequences and random ops against a byte-array memory model.
module tb_riscv_dmws;
  logic clk = 0, rst_n = 0;
  logic req = 0, wen = 0;
  logic [1:0] sel = 0;
  logic [63:0] addr = 0, wdata = 0, rdata;
  logic stall, done, mis;
  logic b_req = 0, b_wen = 0;
  logic [63:0] b_wdata = 0, b_rdata;
  logic b_stall, b_done, b_mis;
  int checks = 0, failures = 0;
  logic [7:0] ref_mem [8192];
  always #5 clk = ~clk;
  riscv_dmws u_dut (
    .i_riscv_dmws_clk(clk), .i_riscv_dmws_rst(rst_n), .i_riscv_dmws_req(req),
    .i_riscv_dmws_wen(wen), .i_riscv_dmws_sel(sel), .i_riscv_dmws_addr(addr),
    .i_riscv_dmws_wdata(wdata), .o_riscv_dmws_rdata(rdata), .o_riscv_dmws_stall(stall),
    .o_riscv_dmws_done(done), .o_riscv_dmws_misalign(mis)
  );
  riscv_dmws #(.WAIT_RD(0), .WAIT_WR(0)) u_byp (
    .i_riscv_dmws_clk(clk), .i_riscv_dmws_rst(rst_n), .i_riscv_dmws_req(b_req),
    .i_riscv_dmws_wen(b_wen), .i_riscv_dmws_sel(2'd3), .i_riscv_dmws_addr(64'h8),
    .i_riscv_dmws_wdata(b_wdata), .o_riscv_dmws_rdata(b_rdata), .o_riscv_dmws_stall(b_stall),
    .o_riscv_dmws_done(b_done), .o_riscv_dmws_misalign(b_mis)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic ref_mis(input logic [1:0] s, input logic [63:0] a);
    return (int'(a[2:0]) % (1 << s)) != 0;
  endfunction
  function automatic logic [63:0] ref_load(input logic [1:0] s, input logic [63:0] a);
    logic [63:0] r = '0;
    if (ref_mis(s, a)) return '0;
    for (int i = 0; i < (1 << s); i++) r[8*i +: 8] = ref_mem[a[12:0] + 13'(i)];
    return r;
  endfunction
  task automatic ref_store(input logic [1:0] s, input logic [63:0] a, input logic [63:0] d);
    if (!ref_mis(s, a))
      for (int i = 0; i < (1 << s); i++) ref_mem[a[12:0] + 13'(i)] = d[8*i +: 8];
  endtask
  task automatic acc(input logic w, input logic [1:0] s, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic m);
    int nst = 0, wt = w ? 1 : 2;
    bit seen = 0;
    req = 1; wen = w; sel = s; addr = a; wdata = d; rd = '0; m = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (done) begin
        seen = 1; rd = rdata; m = mis;
        chk("stall_at_done", 64'(stall), 64'(0));
        chk("latency", 64'(c), 64'(wt + 1));
      end else begin
        nst += int'(stall);
        @(negedge clk);
      end
    end
    if (!seen) chk("done_timeout", 64'(0), 64'(1));
    chk("stall_cycles", 64'(nst), 64'(wt + 1));
    req = 0; wen = 0; addr = '0; wdata = '0;
    @(negedge clk);
    #1 chk("done_single_pulse", 64'(done), 64'(0));
  endtask
  typedef struct { logic w; logic [1:0] s; logic [63:0] a, d, er; logic em; } vec_t;
  vec_t tbl [14];
  logic [63:0] rd, a, d, er;
  logic m, w, em;
  logic [1:0] s;
  initial begin
    tbl[0]  = '{1, 2'd3, 64'h10,   64'hDEADBEEF_CAFEF00D, 64'h0, 0};
    tbl[1]  = '{0, 2'd3, 64'h10,   64'h0, 64'hDEADBEEF_CAFEF00D, 0};
    tbl[2]  = '{1, 2'd0, 64'h13,   64'h12345678_9ABCDEAA, 64'h0, 0};
    tbl[3]  = '{0, 2'd3, 64'h10,   64'h0, 64'hDEADBEEF_AAFEF00D, 0};
    tbl[4]  = '{0, 2'd1, 64'h12,   64'h0, 64'h00000000_0000AAFE, 0};
    tbl[5]  = '{0, 2'd3, 64'h2010, 64'h0, 64'hDEADBEEF_AAFEF00D, 0};
    tbl[6]  = '{1, 2'd3, 64'h20,   64'h11112222_33334444, 64'h0, 0};
    tbl[7]  = '{1, 2'd2, 64'h22,   64'hFFFFFFFF_FFFFFFFF, 64'h0, 1};
    tbl[8]  = '{0, 2'd3, 64'h20,   64'h0, 64'h11112222_33334444, 0};
    tbl[9]  = '{0, 2'd2, 64'h21,   64'h0, 64'h0, 1};
    tbl[10] = '{0, 2'd2, 64'h14,   64'h0, 64'h00000000_DEADBEEF, 0};
    tbl[11] = '{0, 2'd0, 64'h17,   64'h0, 64'h00000000_000000DE, 0};
    tbl[12] = '{1, 2'd1, 64'h26,   64'hFFFF0000_0000BEEF, 64'h0, 0};
    tbl[13] = '{0, 2'd3, 64'h20,   64'h0, 64'hBEEF2222_33334444, 0};
    #1;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_misalign", 64'(mis), 64'(0));
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_byp_done", 64'(b_done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    foreach (tbl[i]) begin
      acc(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, rd, m);
      if (tbl[i].w) ref_store(tbl[i].s, tbl[i].a, tbl[i].d);
      else chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("tbl%0d_misalign", i), 64'(m), 64'(tbl[i].em));
    end
    // reset while the load is waiting in BUSY
    req = 1; wen = 0; sel = 2'd3; addr = 64'h10;
    #1 chk("acc_cycle_stall", 64'(stall), 64'(1));
    @(negedge clk);
    #1 chk("busy_stall", 64'(stall), 64'(1));
    rst_n = 0;
    #1;
    chk("midrst_stall", 64'(stall), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_rdata", rdata, 64'h0);
    @(negedge clk);
    rst_n = 1; req = 0;
    @(negedge clk);
    #1 chk("postrst_done", 64'(done), 64'(0));
    acc(0, 2'd3, 64'h10, 64'h0, rd, m);
    chk("postrst_load", rd, 64'hDEADBEEF_AAFEF00D);
    // abort: req dropped during the first BUSY cycle
    req = 1; wen = 0; sel = 2'd3; addr = 64'h20;
    @(negedge clk);
    req = 0;
    #1 chk("abort_c1_done", 64'(done), 64'(0));
    @(negedge clk);
    #1 chk("abort_c2_stall", 64'(stall), 64'(0));
    chk("abort_c2_done", 64'(done), 64'(0));
    @(negedge clk);
    #1 chk("abort_c3_done", 64'(done), 64'(0));
    chk("abort_rdata_kept", rdata, 64'hDEADBEEF_AAFEF00D);
    acc(0, 2'd3, 64'h20, 64'h0, rd, m);
    chk("after_abort_load", rd, 64'hBEEF2222_33334444);
    // randomized traffic over words 0..15 with random upper (aliasing) address bits
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      acc(1, 2'd3, 64'(i * 8), d, rd, m);
      ref_store(2'd3, 64'(i * 8), d);
    end
    for (int i = 0; i < 80; i++) begin
      a = {$urandom, $urandom};
      a[12:7] = '0;
      s = 2'($urandom);
      w = 1'($urandom);
      d = {$urandom, $urandom};
      em = ref_mis(s, a);
      er = ref_load(s, a);
      acc(w, s, a, d, rd, m);
      chk($sformatf("rnd%0d_misalign", i), 64'(m), 64'(em));
      if (w) ref_store(s, a, d);
      else chk($sformatf("rnd%0d_rdata a=%h s=%0d", i, a, s), rd, er);
    end
    // zero-wait instance: alternating store/load every cycle
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      b_req = 1; b_wen = 1; b_wdata = d;
      #1;
      chk("byp_st_stall", 64'(b_stall), 64'(0));
      chk("byp_st_done", 64'(b_done), 64'(1));
      @(negedge clk);
      b_wen = 0;
      #1;
      chk("byp_ld_stall", 64'(b_stall), 64'(0));
      chk("byp_ld_done", 64'(b_done), 64'(1));
      chk("byp_ld_misalign", 64'(b_mis), 64'(0));
      chk("byp_ld_rdata", b_rdata, d);
      @(negedge clk);
    end
    b_req = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_dmws.md
# riscv_dmws

Parametrised data memory with configurable read/write wait states. It is the successor to the single-cycle data memory on the RV64I memory stage. It accepts one load or store per request from the memory stage. It holds the pipeline through a stall output until the access completes, then pulses done. Loads are returned lane-aligned; sign/zero extension remains in the datapath.

## Interface
Parameters:
- XLEN, 64: data and address width.
- DEPTH, 1024: number of XLEN-bit words; power of two.
- WAIT_RD, 2: extra cycles per load; 0 = zero-wait.
- WAIT_WR, 1: extra cycles per store; 0 = zero-wait.

Ports:
- i_riscv_dmws_clk  in  1  clock; all state updates on the rising edge.
- i_riscv_dmws_rst  in  1  asynchronous, active-low reset.
- i_riscv_dmws_req  in  1  memory-stage access valid; held stable while stall=1.
- i_riscv_dmws_wen  in  1  1 = store, 0 = load.
- i_riscv_dmws_sel  in  2  size: 00 byte, 01 half, 10 word, 11 dword.
- i_riscv_dmws_addr  in  XLEN  byte address.
- i_riscv_dmws_wdata  in  XLEN  store data, right-aligned.
- o_riscv_dmws_rdata  out  XLEN  load data, right-shifted to bit 0, upper bits zero.
- o_riscv_dmws_stall  out  1  to hazard unit; freezes PC and the FD, DE and EM registers.
- o_riscv_dmws_done  out  1  one-cycle completion pulse.
- o_riscv_dmws_misalign  out  1  qualifies done: access was misaligned and was suppressed.

## Operation
Word index and byte offset:
- Word index = addr[$clog2(DEPTH)+2:3], i.e. the address wraps modulo DEPTH words.
- Byte offset = addr[2:0].

Alignment rule: the access is misaligned when the offset is not a multiple of the size (half: off[0]≠0; word: off[1:0]≠0; dword: off≠0).

Stores:
- Merge byte-enables into the addressed word; untouched bytes are preserved.
- Misaligned stores write nothing.

Loads:
- rdata = word >> (8·off), masked to size.
- Misaligned loads return 0.

FSM states: IDLE, BUSY, DONE. Let W = WAIT_WR if wen else WAIT_RD.
- IDLE, req=1, W>0: capture addr/sel/wen/wdata, load counter with W−1, go to BUSY.
- IDLE, req=1, W=0 (bypass): stay in IDLE.
  - Load: rdata is combinational from the array.
  - Store: commits at this edge.
  - done=1 and stall=0 in the same cycle.
- BUSY, counter>0: decrement.
- BUSY, counter=0: perform the access at the edge (store commit, or load data registered into rdata) and go to DONE.
- BUSY, req=0: this is a flush/abort. Go to IDLE with no write and rdata unchanged.
- DONE: done=1 and stall=0. Go to IDLE unconditionally; the req seen in this cycle is the old one and is not re-accepted.

Outputs:
- stall = (IDLE & req & W>0) | BUSY. This is combinational so the hazard unit sees it in the acceptance cycle.
- misalign is valid only while done=1; it is 0 otherwise.
- Registered rdata holds its value until the next completing load.

Storage:
- Array contents are not reset.
- The counter width is $clog2(max(WAIT_RD,WAIT_WR)+1), minimum 1 bit.

## Timing
- Reset (asserted asynchronously, at any time):
  - State goes to IDLE.
  - stall, done, misalign and registered rdata all go to 0.
  - A pending store in BUSY is dropped.
- Released-reset cycle: IDLE; a req is accepted on the first clock edge after deassertion.
- Access with W>0, request seen in cycle 0:
  - stall=1 in cycles 0..W (W+1 cycles).
  - done=1 in cycle W+1.
  - Store visible to a load issued after done.
- Back-to-back accesses: at least one IDLE cycle follows DONE, so throughput is one access per W+2 cycles.
- Bypass (W=0): zero latency, one access per cycle.
- wen, sel, addr and wdata are ignored while in BUSY and DONE; only the values captured in IDLE are used.
- A load after a store to the same word always observes the store. The store commits at or before its done.

## Test plan
- Reset mid-access: WAIT_RD=2, load issued, rst low in cycle 1 → stall=0, done=0, rdata=0 immediately; after release the next load is accepted normally.
- Wait-state timing: WAIT_WR=1, store dword 0xDEADBEEF_CAFEF00D to 0x10; then WAIT_RD=2, load 0x10 → store stall=1 for 2 cycles then done; load stall=1 for 3 cycles, done in the 4th, rdata=0xDEADBEEF_CAFEF00D.
- Byte merge: store byte 0xAA to 0x13 over the word above, then load dword 0x10 → 0xDEADBEEF_AAFEF00D; load half 0x12 → 0x0000_0000_0000_AAFE.
- Misalign and wrap-around:
  - Store word to 0x22 → done=1 with misalign=1 and memory unchanged; load word 0x21 → rdata=0 and misalign=1.
  - With DEPTH=1024, address 0x2010 aliases to 0x10.
- Abort: load accepted, req dropped in the first BUSY cycle → IDLE next cycle, no done pulse, rdata unchanged.
- Bypass: WAIT_RD=WAIT_WR=0, alternating store/load each cycle to 0x8 → stall never asserted, done every cycle, each load returns the prior store's data.
